intc_prio: RTL and testbench
============================

# intc_prio

Parametrised nested-priority interrupt controller sitting between external interrupt sources and the single-cycle control unit. It edge-detects and latches requests, applies a mask, and tracks an in-service register for nesting. It presents the control unit with a one-hot call vector and clears state on call acknowledge and on `reti`. This supersedes the purely combinational priority comparison done inside the control unit.

## Interface
- `N_IRQ`, 8: number of interrupt channels.
  - Index 0 is highest priority.
  - Vectors are one-hot, matching the 8-bit `s_calli`/`s_reti` format.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq`  in  N_IRQ  raw request lines; a rising edge latches a request.
- `exc`  in  1  synchronous exception (ALU overflow); sets pending bit 0 directly, non-maskable.
- `mask_we`  in  1  mask register write strobe.
- `mask_d`  in  N_IRQ  mask write data; 1 = channel enabled.
- `ack`  in  1  control unit is issuing the interrupt call this cycle.
- `reti`  in  1  control unit is executing `reti` this cycle.
- `req`  out  1  an eligible interrupt is waiting.
- `req_vec`  out  N_IRQ  one-hot channel to call (feeds `s_calli`); all zeros when `req`=0.
- `isr`  out  N_IRQ  in-service register (feeds `s_reti` selection).
- `pending`  out  N_IRQ  latched requests not yet taken.

## Operation
- State registers: `irq_q`, `pending`, `mask`, `isr`.
  - All reset to 0, so only channel 0 is enabled out of reset.
  - An `irq` line already high when reset releases counts as a rising edge on the first clock.
- Edge set: `set = (irq & ~irq_q)`, with bit 0 also set by `exc`.
- Eligibility:
  - `elig = pending & mask_eff`, where `mask_eff` is `mask` with bit 0 forced to 1.
  - `cand` = lowest set bit of `elig`.
  - `cur` = lowest set bit of `isr`.
- Request, combinational from registers:
  - `req` = `cand`≠0 and (`isr`=0 or index(`cand`) < index(`cur`)).
  - `req_vec` = `cand` when `req`=1, else 0.
- Acknowledge:
  - `ack`=1 with `req`=1: clear `pending[cand]` and set `isr[cand]` at the edge.
  - `ack` with `req`=0 is ignored.
- Return: `reti`=1 clears `cur` in `isr`. `reti` with `isr`=0 is ignored.
- Simultaneous events: every update uses pre-edge values.
  - `pending_next = (pending & ~ack_clr) | set`, so a new edge on the channel being acknowledged stays pending.
  - `isr_next = (isr & ~reti_clr) | ack_set`. `ack` and `reti` in the same cycle are both applied.
- Mask:
  - `mask_we` loads `mask_d` at the edge; bit 0 is stored but ignored.
  - A masked channel keeps its pending bit.
- `isr` never shrinks except through `reti` or reset.

## Timing
- Edge on `irq[k]` at edge T: `pending[k]`=1 after T+1 (one cycle to sample `irq_q`, one to latch).
- `req`/`req_vec` are valid in the same cycle `pending` becomes visible; zero added latency.
- `exc` sampled high at edge T: `pending[0]`=1 after T, and `req`=1 in the following cycle.
- `ack` to `isr` update: one edge; `req` re-evaluates the next cycle.
- Reset asserted mid-operation: all registers clear immediately (asynchronous); `req`=0 without waiting for a clock.

## Configuration
- `INTC_NEST_EN`:
  - Defined: nesting as described; a higher-priority channel preempts an in-service lower one.
  - Undefined: `req` requires `isr`=0, so at most one bit of `isr` is ever set and `reti` clears it entirely.

## Structure
- Package `intc_pkg` holds:
  - the default `N_IRQ`;
  - the channel 0 exception index constant;
  - the function returning the index of a one-hot vector, used by the bench.
- Sub-module `lsb_isolate` (parameter `W`) returns the lowest set bit as one-hot. It is instantiated twice, for `cand` and for `cur`.

## Test plan
All scenarios use `N_IRQ`=8.
- Basic call and return:
  - Stimulus: after reset, `mask`=8'hFF, pulse `irq[3]`.
  - Required: `pending`=8'h08, `req`=1, `req_vec`=8'h08.
  - Then `ack`: `isr`=8'h08, `pending`=0, `req`=0. Then `reti`: `isr`=0.
- Nesting:
  - Stimulus: `isr`=8'h08, pulse `irq[5]`.
  - Required: `req`=0 (lower priority).
  - Then pulse `irq[1]`: `req_vec`=8'h02. `ack` gives `isr`=8'h0A. `reti` gives `isr`=8'h08 and `req_vec`=8'h20 stays blocked.
- Exception:
  - Stimulus: `mask`=0, assert `exc` for one cycle.
  - Required: `req_vec`=8'h01 despite the mask.
- Collision:
  - Stimulus: `ack` of channel 2 in the same cycle a new edge arrives on `irq[2]`.
  - Required: `pending[2]` stays 1 and `isr[2]`=1.
- Reset mid-service:
  - Stimulus: `isr`=8'h0A and `pending`=8'h30, then drop `reset` between clock edges.
  - Required: all outputs read 0 before the next edge.
- `INTC_NEST_EN` undefined:
  - Stimulus: repeat the nesting scenario.
  - Required: `irq[1]` produces no `req` until `reti`; then `req_vec`=8'h02.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared constants and helpers for the intc_prio interrupt controller.
package intc_pkg;

  // Default number of interrupt channels.
  localparam int N_IRQ_DEF = 8;

  // Channel used by the synchronous (non-maskable) exception.
  localparam int EXC_IDX = 0;

  // Index of the lowest set bit of a (one-hot) vector, -1 when the vector is zero.
  function automatic int onehot_index(input logic [31:0] v);
    for (int i = 0; i < 32; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

endpackage

// File: rtl/lsb_isolate.sv
// Returns the lowest set bit of a vector as a one-hot vector (zero in, zero out).
module lsb_isolate #(
  parameter int W = 8
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] lsb
);

  // Two's-complement trick: vec & -vec keeps only the lowest set bit.
  assign lsb = vec & (~vec + W'(1));

endmodule

// File: rtl/intc_prio.sv
// Nested-priority interrupt controller. Channel 0 is the highest priority and
// is also set directly by the synchronous exception input.
// Optional feature macro: INTC_NEST_EN (defined = nesting/preemption allowed,
// undefined = single-level, req only while nothing is in service).
//
// Handshake: req/req_vec are a level "valid" derived purely from registers;
// the control unit takes the call by raising ack in a cycle where req=1, and
// the transfer completes at that rising edge. ack while req=0 is ignored.
module intc_prio
  import intc_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             exc,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_d,
  input  logic             ack,
  input  logic             reti,
  output logic             req,
  output logic [N_IRQ-1:0] req_vec,
  output logic [N_IRQ-1:0] isr,
  output logic [N_IRQ-1:0] pending
);

  // irq_s samples the raw lines; irq_q holds the previous sample for edge detect.
  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pend_r;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] isr_r;

  logic [N_IRQ-1:0] mask_eff;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] cur;
  logic [N_IRQ-1:0] set;
  logic [N_IRQ-1:0] ack_set;
  logic [N_IRQ-1:0] reti_clr;

  // Channel 0 is never masked; its stored mask bit is ignored.
  always_comb begin
    mask_eff          = mask;
    mask_eff[EXC_IDX] = 1'b1;
  end

  assign elig = pend_r & mask_eff;

  lsb_isolate #(.W(N_IRQ)) u_cand (.vec(elig),  .lsb(cand));
  lsb_isolate #(.W(N_IRQ)) u_cur  (.vec(isr_r), .lsb(cur));

  // Request decision; both vectors are one-hot so a numeric compare orders priority.
  always_comb begin
`ifdef INTC_NEST_EN
    req = (cand != '0) && ((isr_r == '0) || (cand < cur));
`else
    req = (cand != '0) && (isr_r == '0);
`endif
    req_vec = req ? cand : '0;
  end

  // Set/clear terms for the pending and in-service registers.
  always_comb begin
    set          = irq_s & ~irq_q;
    set[EXC_IDX] = set[EXC_IDX] | exc;
    ack_set      = (ack && req) ? cand : '0;
`ifdef INTC_NEST_EN
    reti_clr     = reti ? cur : '0;
`else
    reti_clr     = reti ? isr_r : '0;
`endif
  end

  // State registers; every update uses pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_s  <= '0;
      irq_q  <= '0;
      pend_r <= '0;
      mask   <= '0;
      isr_r  <= '0;
    end else begin
      irq_s  <= irq;
      irq_q  <= irq_s;
      pend_r <= (pend_r & ~ack_set) | set;
      isr_r  <= (isr_r & ~reti_clr) | ack_set;
      if (mask_we) mask <= mask_d;
    end
  end

  assign isr     = isr_r;
  assign pending = pend_r;

endmodule

// File: tb/tb_intc_prio.sv
// Self-checking bench for intc_prio: hand-computed vector table, hand-written
// nesting/reset sequences and a randomized run against a behavioural model.
module tb_intc_prio;
  import intc_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] irq;
  logic       exc;
  logic       mask_we;
  logic [7:0] mask_d;
  logic       ack;
  logic       reti;
  logic       req;
  logic [7:0] req_vec;
  logic [7:0] isr;
  logic [7:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  intc_prio #(.N_IRQ(8)) dut (
    .clk(clk), .reset(reset), .irq(irq), .exc(exc), .mask_we(mask_we),
    .mask_d(mask_d), .ack(ack), .reti(reti), .req(req), .req_vec(req_vec),
    .isr(isr), .pending(pending)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: per-channel flags plus the last two sampled irq values.
  logic [7:0] m_pend, m_isr, m_mask, m_s1, m_s2;

  function automatic int m_cand();
    for (int k = 0; k < 8; k++)
      if (m_pend[k] && (k == EXC_IDX || m_mask[k])) return k;
    return -1;
  endfunction

  function automatic int m_cur();
    for (int k = 0; k < 8; k++)
      if (m_isr[k]) return k;
    return -1;
  endfunction

  function automatic logic m_req();
    int c, u;
    c = m_cand();
    u = m_cur();
    if (c < 0) return 1'b0;
    if (u < 0) return 1'b1;
`ifdef INTC_NEST_EN
    return c < u;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] m_vec();
    logic [7:0] v;
    v = '0;
    if (m_req()) v[m_cand()] = 1'b1;
    return v;
  endfunction

  task automatic m_reset();
    m_pend = '0; m_isr = '0; m_mask = '0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_req"},     {31'd0, req}, {31'd0, m_req()});
    check({tag, "_vec"},     {24'd0, req_vec}, {24'd0, m_vec()});
    check({tag, "_isr"},     {24'd0, isr}, {24'd0, m_isr});
    check({tag, "_pending"}, {24'd0, pending}, {24'd0, m_pend});
  endtask

  // Driver: apply inputs, advance one clock, update the model, compare.
  task automatic cycle(input logic [7:0] i_irq, input logic i_exc, input logic i_mwe,
                       input logic [7:0] i_md, input logic i_ack, input logic i_reti);
    logic [7:0] np, ni;
    int c, u;
    logic r;
    irq = i_irq; exc = i_exc; mask_we = i_mwe; mask_d = i_md; ack = i_ack; reti = i_reti;
    c = m_cand(); u = m_cur(); r = m_req();
    for (int k = 0; k < 8; k++) begin
      np[k] = (m_pend[k] && !(i_ack && r && k == c)) || (m_s1[k] && !m_s2[k]) ||
              (k == EXC_IDX && i_exc);
      ni[k] = (m_isr[k] && !(i_reti && k == u)) || (i_ack && r && k == c);
    end
    @(posedge clk);
    #1;
    m_pend = np;
    m_isr  = ni;
    m_s2   = m_s1;
    m_s1   = i_irq;
    if (i_mwe) m_mask = i_md;
    check_model("model");
  endtask

  task automatic idle();
    cycle(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse(input int k);
    cycle(8'(1) << k, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
  endtask

  task automatic do_ack();
    cycle(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reti();
    cycle(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [7:0] irq;
    logic       exc;
    logic       mwe;
    logic [7:0] md;
    logic       ack;
    logic       reti;
    logic       e_req;
    logic [7:0] e_vec;
    logic [7:0] e_isr;
    logic [7:0] e_pend;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Hand-computed vectors: basic call/return, exception, collision.
    tbl[0]  = '{8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h08, 8'h00, 8'h08};
    tbl[3]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h08, 8'h00};
    tbl[4]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h01};
    tbl[7]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00};
    tbl[8]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h04, 8'h00, 8'h04};
    tbl[12] = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h04, 8'h00, 8'h04};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 8'h04};
    tbl[14] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 8'h00, 8'h04};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 8'h00};
    tbl[16] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};

    irq = '0; exc = 1'b0; mask_we = 1'b0; mask_d = '0; ack = 1'b0; reti = 1'b0;
    reset = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].irq, tbl[i].exc, tbl[i].mwe, tbl[i].md, tbl[i].ack, tbl[i].reti);
      check($sformatf("tbl%0d_req", i),  {31'd0, req},     {31'd0, tbl[i].e_req});
      check($sformatf("tbl%0d_vec", i),  {24'd0, req_vec}, {24'd0, tbl[i].e_vec});
      check($sformatf("tbl%0d_isr", i),  {24'd0, isr},     {24'd0, tbl[i].e_isr});
      check($sformatf("tbl%0d_pend", i), {24'd0, pending}, {24'd0, tbl[i].e_pend});
    end

    // Nesting scenario (mask is 8'hFF, state is clean).
    pulse(3);
    do_ack();
    check("nest_isr3", {24'd0, isr}, 32'h08);
    pulse(5);
    check("nest_low_blocked", {31'd0, req}, 32'd0);
    pulse(1);
`ifdef INTC_NEST_EN
    check("nest_preempt_vec", {24'd0, req_vec}, 32'h02);
    do_ack();
    check("nest_isr_0a", {24'd0, isr}, 32'h0A);
    do_reti();
    check("nest_reti_isr", {24'd0, isr}, 32'h08);
    check("nest_20_blocked", {31'd0, req}, 32'd0);
    check("nest_20_pending", {24'd0, pending}, 32'h20);
    do_reti();
    check("nest_20_vec", {24'd0, req_vec}, 32'h20);
    do_ack();
    do_reti();
`else
    check("flat_blocked", {31'd0, req}, 32'd0);
    do_reti();
    check("flat_reti_isr", {24'd0, isr}, 32'h00);
    check("flat_vec_after_reti", {24'd0, req_vec}, 32'h02);
    do_ack();
    check("flat_isr_02", {24'd0, isr}, 32'h02);
    do_reti();
    do_ack();
    do_reti();
`endif
    check("clean_isr", {24'd0, isr}, 32'h00);
    check("clean_pending", {24'd0, pending}, 32'h00);

    // Reset mid-service, dropped between clock edges.
    pulse(3);
    do_ack();
    pulse(1);
    do_ack();
    pulse(4);
    pulse(5);
`ifdef INTC_NEST_EN
    check("pre_reset_isr", {24'd0, isr}, 32'h0A);
    check("pre_reset_pending", {24'd0, pending}, 32'h30);
`endif
    reset = 1'b0;
    #2;
    check("async_rst_req", {31'd0, req}, 32'd0);
    check("async_rst_vec", {24'd0, req_vec}, 32'd0);
    check("async_rst_isr", {24'd0, isr}, 32'd0);
    check("async_rst_pending", {24'd0, pending}, 32'd0);
    m_reset();
    reset = 1'b1;

    // Randomized run against the model.
    cycle(8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r_irq;
      r_irq = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : irq;
      cycle(r_irq, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
      if (m_req())
        check("rand_vec_index", onehot_index({24'd0, req_vec}), m_cand());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
